// File: rtl/uart_rx_os.sv
// UART 8N1 receiver with 16x oversampling and 3-sample majority voting.
// Emits validated bytes as a one-cycle rx_valid pulse and flags bad stop bits on rx_error.
module uart_rx_os #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 rx_error
);

    localparam int TICK_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SAMP_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [SAMP_W-1:0] VOTE_A    = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] VOTE_B    = SAMP_W'(OVERSAMPLE / 2);
    localparam logic [SAMP_W-1:0] VOTE_C    = SAMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;

    logic                   r_rxMeta;
    logic                   r_rxSync;
    logic [TICK_W-1:0]      r_tickCnt;
    logic [SAMP_W-1:0]      r_sampleCnt;
    logic                   r_vote0;
    logic                   r_vote1;
    logic [BIT_W-1:0]       r_bitIdx;
    logic [DATA_BITS-1:0]   r_shiftReg;
    logic [DATA_BITS-1:0]   r_rxData;
    logic                   r_rxValid;
    logic                   r_rxError;

    logic                   w_counting;
    logic                   w_tick;
    logic                   w_decide;
    logic                   w_majority;
    logic                   w_validNext;
    logic                   w_errorNext;
    logic                   w_busy;

    assign w_counting = (r_state == START) || (r_state == DATA) || (r_state == STOP);
    assign w_tick     = w_counting && (r_tickCnt == TICK_LAST);
    assign w_decide   = w_tick && (r_sampleCnt == VOTE_C);
    assign w_majority = (r_vote0 & r_vote1) | (r_vote0 & r_rxSync) | (r_vote1 & r_rxSync);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
        end
    end

    // Counters sit at zero while not receiving, so entering START starts a fresh bit timeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tickCnt   <= '0;
            r_sampleCnt <= '0;
        end else if (!w_counting) begin
            r_tickCnt   <= '0;
            r_sampleCnt <= '0;
        end else begin
            r_tickCnt <= w_tick ? '0 : r_tickCnt + 1'b1;
            if (w_tick) begin
                r_sampleCnt <= (r_sampleCnt == SAMP_LAST) ? '0 : r_sampleCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vote0 <= 1'b0;
            r_vote1 <= 1'b0;
        end else if (w_tick) begin
            if (r_sampleCnt == VOTE_A) r_vote0 <= r_rxSync;
            if (r_sampleCnt == VOTE_B) r_vote1 <= r_rxSync;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_validNext = 1'b0;
        w_errorNext = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rxSync) w_nextState = START;
            end
            START: begin
                w_busy = 1'b1;
                if (w_decide) w_nextState = w_majority ? IDLE : DATA;
            end
            DATA: begin
                w_busy = 1'b1;
                if (w_decide && (r_bitIdx == LAST_BIT)) w_nextState = STOP;
            end
            STOP: begin
                w_busy = 1'b1;
                if (w_decide) begin
                    if (w_majority) begin
                        w_validNext = 1'b1;
                        w_nextState = IDLE;
                    end else begin
                        w_errorNext = 1'b1;
                        w_nextState = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (r_rxSync) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Bits arrive LSB first, so each decision enters at the MSB and walks down.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bitIdx   <= '0;
            r_shiftReg <= '0;
        end else if (r_state != DATA) begin
            r_bitIdx <= '0;
        end else if (w_decide) begin
            r_bitIdx   <= r_bitIdx + 1'b1;
            r_shiftReg <= {w_majority, r_shiftReg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxData  <= '0;
            r_rxValid <= 1'b0;
            r_rxError <= 1'b0;
        end else begin
            r_rxValid <= w_validNext;
            r_rxError <= w_errorNext;
            if (w_validNext) r_rxData <= r_shiftReg;
        end
    end

    assign rx_data  = r_rxData;
    assign rx_valid = r_rxValid;
    assign rx_error = r_rxError;
    assign rx_busy  = w_busy;

endmodule
